// File: rtl/pent_pkg.sv
// Shared constants and types for the Pentagon-style memory pager.
package pent_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } pent_state_t;

  // 7FFD is partially decoded: only A15 and A1 must be zero.
  localparam logic [15:0] PORT_7FFD_MASK = 16'h8002;
  localparam logic [15:0] PORT_EFF7      = 16'hEFF7;

  localparam int PAGE_MAX_W = 6;
  localparam logic [PAGE_MAX_W-1:0] PAGE_2 = 6'd2;
  localparam logic [PAGE_MAX_W-1:0] PAGE_5 = 6'd5;
  localparam logic [PAGE_MAX_W-1:0] PAGE_7 = 6'd7;

  localparam int EFF7_COMPAT_BIT = 2;
  localparam int EFF7_RAM0_BIT   = 3;

  localparam int P7FFD_SCR_BIT  = 3;
  localparam int P7FFD_ROM_BIT  = 4;
  localparam int P7FFD_LOCK_BIT = 5;

endpackage

// File: rtl/pent_strobe_sync.sv
// Two-flop synchroniser for the Z80 IORQ/WR pair plus rising-edge detect
// of the combined write strobe.
module pent_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic iorq,
  input  logic wr,
  output logic strobe,
  output logic rise
);

  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic [1:0] fill_reg;
  logic       hist_reg;
  logic       strobe_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
      fill_reg  <= 2'b00;
      hist_reg  <= 1'b1;
    end else begin
      sync1_reg <= {iorq, wr};
      sync2_reg <= sync1_reg;
      fill_reg  <= {fill_reg[0], 1'b1};
      hist_reg  <= strobe;
    end
  end

  assign strobe_raw = ~sync2_reg[1] & ~sync2_reg[0];

  // Until real pin samples reach the second stage the reset value of the
  // synchroniser is not trusted; report "active" so a strobe held across
  // reset release is never seen as a fresh edge.
  assign strobe = fill_reg[1] ? strobe_raw : 1'b1;
  assign rise   = strobe & ~hist_reg;

endmodule

// File: rtl/pent_pager.sv
// Pentagon-compatible 7FFD/EFF7 memory pager for 128K, 512K and 1024K RAM.
module pent_pager
  import pent_pkg::*;
#(
  parameter int RAM_KB   = 128,
  parameter int EXT_PORT = 1,
  localparam int PW      = $clog2(RAM_KB / 16)
) (
  input  logic          CLK_14MHZ,
  input  logic          RESET,
  input  logic          CPU_IORQ,
  input  logic          CPU_WR,
  input  logic [15:0]   A,
  input  logic [7:0]    D,
  output logic [PW-1:0] MA_PAGE,
  output logic          ROM_SEL,
  output logic          ROM_BANK,
  output logic          SCR_SEL,
  output logic          LOCKED,
  output logic [1:0]    PORT_WR
);

  if (!(RAM_KB == 128 || RAM_KB == 512 || RAM_KB == 1024)) begin : g_bad_ram_kb
    $error("pent_pager: RAM_KB must be 128, 512 or 1024");
  end

  pent_state_t state_reg;
  pent_state_t state_next;

  logic        strobe;
  logic        rise;
  logic        capture;
  logic        hit_7ffd;
  logic        hit_eff7;
  logic        compat;
  logic        lock_active;
  logic        write_ok;
  logic [7:0]  p7ffd_reg;
  logic [7:0]  eff7_reg;
  logic        locked_reg;
  logic [1:0]  port_wr_reg;
  logic [PAGE_MAX_W-1:0] sel_page;
  logic [PAGE_MAX_W-1:0] map_page;
  logic        rom_sel;
  logic        unused_bits;

  pent_strobe_sync u_sync (
    .clk    (CLK_14MHZ),
    .rst    (RESET),
    .iorq   (CPU_IORQ),
    .wr     (CPU_WR),
    .strobe (strobe),
    .rise   (rise)
  );

  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) state_reg <= ST_HOLD;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (rise) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    if (!strobe) state_next = ST_IDLE;
      default:    state_next = ST_HOLD;
    endcase
  end

  always_comb begin
    capture = (state_reg == ST_CAPTURE);
  end

  assign hit_7ffd    = (A & PORT_7FFD_MASK) == 16'h0000;
  assign hit_eff7    = (EXT_PORT != 0) && (A == PORT_EFF7);
  assign compat      = (RAM_KB == 1024) && eff7_reg[EFF7_COMPAT_BIT];
  assign lock_active = (RAM_KB <= 512) || compat;
  assign write_ok    = !(locked_reg && lock_active);

  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) begin
      p7ffd_reg   <= 8'h00;
      eff7_reg    <= 8'h00;
      locked_reg  <= 1'b0;
      port_wr_reg <= 2'b00;
    end else begin
      port_wr_reg <= {capture && hit_eff7, capture && hit_7ffd};
      if (capture && hit_7ffd && write_ok) begin
        p7ffd_reg <= D;
        if (lock_active && D[P7FFD_LOCK_BIT]) locked_reg <= 1'b1;
      end
      if (capture && hit_eff7) eff7_reg <= D;
    end
  end

  // Page bits are assembled from the stored byte on every read, so leaving
  // compat mode brings the upper bits back.
  always_comb begin
    sel_page = {3'b000, p7ffd_reg[2:0]};
    if (RAM_KB == 512)
      sel_page = {1'b0, p7ffd_reg[7:6], p7ffd_reg[2:0]};
    else if (RAM_KB == 1024 && !compat)
      sel_page = {p7ffd_reg[5], p7ffd_reg[7:6], p7ffd_reg[2:0]};
  end

  always_comb begin
    rom_sel  = 1'b0;
    map_page = '0;
    case (A[15:14])
      2'b00:   rom_sel  = !eff7_reg[EFF7_RAM0_BIT];
      2'b01:   map_page = PAGE_5;
      2'b10:   map_page = PAGE_2;
      default: map_page = sel_page;
    endcase
  end

  assign MA_PAGE  = map_page[PW-1:0];
  assign ROM_SEL  = rom_sel;
  assign ROM_BANK = p7ffd_reg[P7FFD_ROM_BIT];
  assign SCR_SEL  = p7ffd_reg[P7FFD_SCR_BIT];
  assign LOCKED   = locked_reg;
  assign PORT_WR  = port_wr_reg;

  assign unused_bits = ^{map_page, eff7_reg[7:4], eff7_reg[1:0], A[13:0]};

endmodule

// File: doc/pent_pager.md
PENT_PAGER -- requirements
Module: pent_pager

Interface
REQ-001 Parameter RAM_KB, default 128, installed RAM size: 128, 512 or 1024; any other value is an elaboration error.
REQ-002 Parameter EXT_PORT, default 1, enables port EFF7; when 0, EFF7 writes are ignored and its register stays 0.
REQ-003 Derived constant PW = log2(RAM_KB/16), giving 3, 5 or 6.
REQ-004 CLK_14MHZ  in  1  system clock; all state is on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 CPU_IORQ, CPU_WR  in  1 each  Z80 strobes, active-low, asynchronous to CLK_14MHZ.
REQ-007 A  in  16  CPU address.
REQ-008 D  in  8  CPU data.
REQ-009 MA_PAGE  out  PW  physical 16K RAM page for the current A[15:14].
REQ-010 ROM_SEL  out  1  high when the current access targets ROM.
REQ-011 ROM_BANK  out  1  7FFD bit 4.
REQ-012 SCR_SEL  out  1  7FFD bit 3; 0 selects page 5, 1 selects page 7.
REQ-013 LOCKED  out  1  7FFD lock state.
REQ-014 PORT_WR  out  2  one-cycle capture pulses: bit 0 for 7FFD, bit 1 for EFF7.

Function
REQ-015 The concatenation {IORQ,WR} SHALL pass through a 2-flop synchroniser; strobe = both synchronised lines low.
REQ-016 FSM states: IDLE, CAPTURE, HOLD.
- IDLE -> CAPTURE on an inactive-to-active strobe transition.
- CAPTURE lasts exactly 1 cycle -> HOLD.
- HOLD -> IDLE when strobe is inactive.
REQ-017 In CAPTURE, A and D SHALL be sampled directly. Write latency: 3 cycles from strobe assertion at the pins to the register update.
REQ-018 The 7FFD decode SHALL be A15=0 and A1=0 (partial decode).
REQ-019 The EFF7 decode SHALL be A==16'hEFF7 and EXT_PORT=1. The two decodes are mutually exclusive via A1.
REQ-020 A 7FFD write SHALL be discarded when LOCKED=1 and lock is active (see REQ-021). PORT_WR[0] still pulses.
REQ-021 Lock is active when RAM_KB<=512, or when RAM_KB=1024 and EFF7 bit 2 = 1 (compat mode).
REQ-022 When lock is active, D5=1 on an accepted write SHALL set LOCKED. LOCKED clears only on RESET.
REQ-023 The selected page SHALL be built per size and mode:
- 128: D[2:0].
- 512: {D7,D6,D2:D0}.
- 1024, compat=0: {D5,D7,D6,D2:D0}.
- 1024, compat=1: {000,D2:D0}.
REQ-024 When compat switches to 1, MA_PAGE bits above bit 2 SHALL read 0 combinationally. The stored bits are retained.
REQ-025 Mapping by A[15:14], combinational:
- 00: ROM_SEL=1, MA_PAGE=0; if EFF7 bit 3 = 1, ROM_SEL=0 and MA_PAGE=0 (RAM at 0000).
- 01: page 5.
- 10: page 2.
- 11: selected page.
REQ-026 All mapped pages SHALL be zero-extended to PW bits.
REQ-027 A strobe already active when RESET releases SHALL NOT cause a capture. The edge-detect history resets to "active".
REQ-028 RESET asserted mid-HOLD or mid-CAPTURE SHALL abort the capture with no register update.

Reset
REQ-029 RESET SHALL force:
- the 7FFD register, the EFF7 register and LOCKED to 0;
- PORT_WR to 00;
- the FSM to HOLD;
- the synchroniser flops to 1 (inactive).
REQ-030 Out of reset, A[15:14]=00 SHALL give ROM_SEL=1 and MA_PAGE=0.

Structure
REQ-031 A shared package pent_pkg SHALL hold:
- the FSM state enum;
- the port address constants 7FFD mask and EFF7;
- the fixed page constants 2, 5 and 7;
- the EFF7 bit indices.
REQ-032 The synchroniser plus edge detector SHALL be one sub-module, pent_strobe_sync, reused for future ports. The decode, registers and mapping stay in pent_pager.

Verification
REQ-033 RAM_KB=128: write 7FFD=0x13, then A=0xC000 -> MA_PAGE=3, ROM_BANK=1, SCR_SEL=0, LOCKED=0, PORT_WR[0] pulses once.
REQ-034 RAM_KB=128: write 7FFD=0x20, then write 7FFD=0x07 -> LOCKED=1, MA_PAGE at A=0xC000 stays 0, PORT_WR[0] pulses twice; after RESET, LOCKED=0.
REQ-035 RAM_KB=1024, EFF7=0: write 7FFD=0xE5, A=0xC000 -> MA_PAGE=6'b111101, LOCKED=0. Then write EFF7=0x04 -> MA_PAGE=5, and a later 7FFD=0x20 sets LOCKED=1.
REQ-036 Write EFF7=0x08, A=0x0000 -> ROM_SEL=0, MA_PAGE=0. A=0x4000 -> MA_PAGE=5. A=0x8000 -> MA_PAGE=2.
REQ-037 Hold IORQ=WR=0 on 7FFD with D=0x03 across RESET release -> no capture and MA_PAGE=0. Release then reassert -> capture exactly 3 cycles after assertion.
REQ-038 EXT_PORT=0: write EFF7=0x08 -> no PORT_WR[1] pulse and ROM_SEL stays 1 at A=0x0000.
